tw4_cpu: RTL and testbench

- 4-bit single-cycle accumulator CPU (TD4-class ISA) extended with one maskable interrupt level.
- Fetches 8-bit instructions from a combinational ROM over a 4-bit address bus.
- Drives a 4-bit LED output port.
- Talks to a daisy-chained set of button interrupt sources through a per-source enable mask (ie), a shared request line (irq) and an acknowledge strobe (ack).

---
 rtl/tw4_cpu.sv | 100 ++++++++++
 tb/tb_tw4_cpu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tw4_cpu.sv
// rtl/tw4_cpu.sv - 4-bit accumulator CPU with one maskable interrupt level
module tw4_cpu (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] addr,
    input  logic [7:0] data,
    input  logic [3:0] in,
    output logic [3:0] out,
    input  logic       irq,
    output logic [3:0] ie,
    output logic       ack
);
    typedef logic [3:0] addr_t;
    typedef logic [3:0] nibble_t;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_A  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_B  = 4'b0111;
    localparam logic [3:0] OP_EI     = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_RETI   = 4'b1010;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_SETV   = 4'b1100;
    localparam logic [3:0] OP_NOP    = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    nibble_t a_q, b_q, out_q, ie_q;
    addr_t   pc_q, vec_q, spc_q;
    logic    c_q, sc_q, isr_q;

    logic [3:0] op, im;
    logic [4:0] sum_a, sum_b;
    logic       take;

    assign op    = data[7:4];
    assign im    = data[3:0];
    assign sum_a = {1'b0, a_q} + {1'b0, im};
    assign sum_b = {1'b0, b_q} + {1'b0, im};

    // An interrupt is taken only when some source is enabled and no handler is running.
    assign take = irq & ~isr_q & (ie_q != 4'd0);

    assign addr = pc_q;
    assign out  = out_q;
    assign ie   = ie_q;
    assign ack  = take;

    // Architectural state: an accepted interrupt replaces the fetched instruction entirely.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
            pc_q  <= '0;
            out_q <= '0;
            ie_q  <= '0;
            vec_q <= '0;
            spc_q <= '0;
            sc_q  <= 1'b0;
            isr_q <= 1'b0;
        end else if (take) begin
            spc_q <= pc_q;
            sc_q  <= c_q;
            pc_q  <= vec_q;
            isr_q <= 1'b1;
        end else begin
            pc_q <= pc_q + 4'd1;
            c_q  <= 1'b0;
            case (op)
                OP_ADD_A:  {c_q, a_q} <= sum_a;
                OP_ADD_B:  {c_q, b_q} <= sum_b;
                OP_MOV_A:  a_q <= im;
                OP_MOV_B:  b_q <= im;
                OP_MOV_AB: a_q <= b_q;
                OP_MOV_BA: b_q <= a_q;
                OP_IN_A:   a_q <= in;
                OP_IN_B:   b_q <= in;
                OP_OUT_B:  out_q <= b_q;
                OP_OUT_IM: out_q <= im;
                OP_JMP:    pc_q <= im;
                OP_JNC:    if (!c_q) pc_q <= im;
                OP_EI:     ie_q <= im;
                OP_SETV:   vec_q <= im;
                OP_RETI: begin
                    pc_q  <= spc_q;
                    c_q   <= sc_q;
                    isr_q <= 1'b0;
                end
                OP_NOP:    ;
                default:   ;
            endcase
        end
    end
endmodule

// File: tb/tb_tw4_cpu.sv
// tb/tb_tw4_cpu.sv - directed self-checking bench for tw4_cpu
module tb_tw4_cpu;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] addr;
    logic [7:0] data;
    logic [3:0] in_port = 4'd0;
    logic [3:0] out;
    logic       irq = 1'b0;
    logic [3:0] ie;
    logic       ack;

    logic [7:0] rom [16];
    int checks = 0;
    int errors = 0;

    assign data = rom[addr];

    tw4_cpu dut (
        .clock (clock),
        .reset (reset),
        .addr  (addr),
        .data  (data),
        .in    (in_port),
        .out   (out),
        .irq   (irq),
        .ie    (ie),
        .ack   (ack)
    );

    always #5 clock = ~clock;

    // Compare one observed value against its hand-computed expectation.
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 2 time units past it.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) rom[i] = 8'hD0;
    endtask

    // Hold reset over one edge, then release just after an edge.
    task automatic do_reset();
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    initial begin
        fill_nop();
        #1;
        // Reset state
        tick(1);
        chk("rst_addr", {4'd0, addr}, 8'h0);
        chk("rst_out", {4'd0, out}, 8'h0);
        chk("rst_ie", {4'd0, ie}, 8'h0);
        chk("rst_ack", {7'd0, ack}, 8'h0);

        // ALU: A=E+3 -> 1 with carry, JNC falls through
        rom[0] = 8'h3E; rom[1] = 8'h03; rom[2] = 8'hE0; rom[3] = 8'hB5;
        rom[4] = 8'h40; rom[5] = 8'h90; rom[6] = 8'hF6;
        reset = 1'b1;
        tick(1);
        chk("alu_first_fetch", {4'd0, addr}, 8'h1);
        tick(2);
        chk("alu_jnc_fall", {4'd0, addr}, 8'h3);
        tick(1);
        chk("alu_out_im", {4'd0, out}, 8'h5);
        tick(2);
        chk("alu_a_value", {4'd0, out}, 8'h1);
        tick(2);
        chk("alu_jmp_self", {4'd0, addr}, 8'h6);

        // IN/OUT and a two-value output loop
        do_reset();
        fill_nop();
        rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hB1; rom[3] = 8'hB2; rom[4] = 8'hF2;
        in_port = 4'hA;
        tick(2);
        chk("io_out_b", {4'd0, out}, 8'hA);
        tick(1);
        chk("io_loop_1", {4'd0, out}, 8'h1);
        tick(1);
        chk("io_loop_2", {4'd0, out}, 8'h2);
        tick(1);
        chk("io_jmp_addr", {4'd0, addr}, 8'h2);
        tick(1);
        chk("io_loop_1b", {4'd0, out}, 8'h1);

        // Interrupt entry right after a carry-producing ADD
        do_reset();
        fill_nop();
        rom[0] = 8'hCC; rom[1] = 8'h81; rom[2] = 8'h3F; rom[3] = 8'h01;
        rom[4] = 8'hE0; rom[5] = 8'hF5; rom[12] = 8'hBF; rom[13] = 8'hA0;
        tick(2);
        chk("irq_ie_set", {4'd0, ie}, 8'h1);
        tick(2);
        chk("irq_pre_addr", {4'd0, addr}, 8'h4);
        chk("irq_no_ack_idle", {7'd0, ack}, 8'h0);
        irq = 1'b1;
        #1;
        chk("irq_ack_high", {7'd0, ack}, 8'h1);
        tick(1);
        chk("irq_vector", {4'd0, addr}, 8'hC);
        chk("irq_ignored_isr", {7'd0, ack}, 8'h0);
        irq = 1'b0;
        tick(1);
        chk("isr_out_f", {4'd0, out}, 8'hF);
        tick(1);
        chk("reti_addr", {4'd0, addr}, 8'h4);
        tick(1);
        chk("reti_carry_kept", {4'd0, addr}, 8'h5);

        // Second entry interrupts a JMP; the jump re-executes after RETI
        irq = 1'b1;
        #1;
        chk("irq2_ack", {7'd0, ack}, 8'h1);
        tick(1);
        irq = 1'b0;
        chk("irq2_vector", {4'd0, addr}, 8'hC);
        tick(2);
        chk("irq2_reti_addr", {4'd0, addr}, 8'h5);
        tick(1);
        chk("irq2_jmp_again", {4'd0, addr}, 8'h5);

        // Reset inside a handler
        irq = 1'b1;
        tick(1);
        irq = 1'b0;
        chk("irq3_vector", {4'd0, addr}, 8'hC);
        reset = 1'b0;
        #1;
        chk("mid_rst_addr", {4'd0, addr}, 8'h0);
        chk("mid_rst_ie", {4'd0, ie}, 8'h0);
        chk("mid_rst_out", {4'd0, out}, 8'h0);
        tick(1);
        reset = 1'b1;
        tick(2);
        irq = 1'b1;
        #1;
        chk("post_rst_isr_clear", {7'd0, ack}, 8'h1);
        irq = 1'b0;

        // Masking with EI 0, plus PC wrap 15 -> 0
        do_reset();
        fill_nop();
        rom[0] = 8'hCC; rom[1] = 8'h81; rom[2] = 8'h80; rom[3] = 8'hD0; rom[4] = 8'hFF;
        tick(3);
        chk("mask_ie_zero", {4'd0, ie}, 8'h0);
        irq = 1'b1;
        #1;
        chk("mask_no_ack", {7'd0, ack}, 8'h0);
        tick(1);
        chk("mask_flow", {4'd0, addr}, 8'h4);
        chk("mask_no_ack2", {7'd0, ack}, 8'h0);
        tick(1);
        chk("mask_jmp_f", {4'd0, addr}, 8'hF);
        tick(1);
        chk("pc_wrap", {4'd0, addr}, 8'h0);
        irq = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
